// File: rtl/vespa_bus_pkg.sv
// ---------------------------------------------------------------------------
// vespa_bus_pkg
// Shared definitions for the SoC bus master arbiter: default bus width,
// lock timeout default, master index constants and the lock FSM encoding.
// ---------------------------------------------------------------------------
package vespa_bus_pkg;

  localparam int BUS_WIDTH_DEF = 32;
  localparam int MAX_LOCK_DEF  = 16;

  // Master indices into the packed request/grant vectors.
  localparam int M0 = 0;  // VeSPA CPU data port
  localparam int M1 = 1;  // DMA engine

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_e;

endpackage : vespa_bus_pkg

// File: rtl/bus_master_arbiter_arb_rr2.sv
// ---------------------------------------------------------------------------
// arb_rr2
// Two-way round-robin pick. Requests are first filtered by mask_i; when both
// eligible masters request, the one that was NOT granted last wins.
// Ports:
//   req_i  [1:0]  raw requests, bit m = master m
//   last_i        index of the master granted most recently
//   mask_i [1:0]  masters allowed to win this cycle
//   gnt_o  [1:0]  one-hot (or zero) grant
// ---------------------------------------------------------------------------
module arb_rr2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic [1:0] mask_i,
  output logic [1:0] gnt_o
);

  logic [1:0] eligible;

  // NOTE: every signal driven in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    eligible = req_i & mask_i;
    gnt_o    = eligible;
    if (eligible == 2'b11) begin
      gnt_o = last_i ? 2'b01 : 2'b10;
    end
  end

endmodule : arb_rr2

// File: rtl/bus_master_arbiter.sv
// ---------------------------------------------------------------------------
// bus_master_arbiter
// Shares the interconnect master port between M0 (CPU data) and M1 (DMA).
// One operation is granted per cycle, ties go round-robin, and a master may
// hold the bus for an atomic sequence (lock) for at most MAX_LOCK cycles.
// Read data comes back one cycle after the granted read.
// Ports (per master m = 0/1):
//   i_Req_m / i_Wr_m / i_Addr_m / i_WData_m / i_Lock_m  request side
//   o_Gnt_m      combinational grant for this cycle
//   o_RValid_m   read return, one cycle after a granted read
//   o_RData_m    read data, zero when o_RValid_m is low
// Interconnect side:
//   o_WEnable/o_WAddr/o_WData, o_REnable/o_RAddr, i_RData
// ---------------------------------------------------------------------------
module bus_master_arbiter
  import vespa_bus_pkg::*;
#(
  parameter int BUS_WIDTH = BUS_WIDTH_DEF,
  parameter int MAX_LOCK  = MAX_LOCK_DEF
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  // Master 0
  input  logic                 i_Req_0,
  input  logic                 i_Wr_0,
  input  logic [BUS_WIDTH-1:0] i_Addr_0,
  input  logic [BUS_WIDTH-1:0] i_WData_0,
  input  logic                 i_Lock_0,
  output logic                 o_Gnt_0,
  output logic                 o_RValid_0,
  output logic [BUS_WIDTH-1:0] o_RData_0,
  // Master 1
  input  logic                 i_Req_1,
  input  logic                 i_Wr_1,
  input  logic [BUS_WIDTH-1:0] i_Addr_1,
  input  logic [BUS_WIDTH-1:0] i_WData_1,
  input  logic                 i_Lock_1,
  output logic                 o_Gnt_1,
  output logic                 o_RValid_1,
  output logic [BUS_WIDTH-1:0] o_RData_1,
  // Interconnect
  output logic                 o_WEnable,
  output logic [BUS_WIDTH-1:0] o_WAddr,
  output logic [BUS_WIDTH-1:0] o_WData,
  output logic                 o_REnable,
  output logic [BUS_WIDTH-1:0] o_RAddr,
  input  logic [BUS_WIDTH-1:0] i_RData
);

  localparam int               CNT_W   = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

  arb_state_e       state_q;
  logic [CNT_W-1:0] lock_cnt_q;
  logic [CNT_W-1:0] lock_cnt_inc;
  logic             last_q;
  logic [1:0]       rd_pend_q;
  logic [1:0]       rd_pend_d;

  logic [1:0] req;
  logic [1:0] wr;
  logic [1:0] mask;
  logic [1:0] pick;
  logic [1:0] gnt;
  logic       owner_lock;
  logic       lock_timeout;

  assign req = {i_Req_1, i_Req_0};
  assign wr  = {i_Wr_1, i_Wr_0};

  // While locked only the owner is eligible; the other master simply waits.
  always_comb begin
    mask = 2'b11;
    case (state_q)
      ST_LOCK0: mask = 2'b01;
      ST_LOCK1: mask = 2'b10;
      default:  mask = 2'b11;
    endcase
  end

  arb_rr2 u_arb_rr2 (
    .req_i  (req),
    .last_i (last_q),
    .mask_i (mask),
    .gnt_o  (pick)
  );

  // Grants are combinational; gating with reset keeps every output at 0
  // while reset is asserted, not only the registered ones.
  assign gnt     = i_Rst_n ? pick : 2'b00;
  assign o_Gnt_0 = gnt[M0];
  assign o_Gnt_1 = gnt[M1];

  // Saturating increment. The lock ends in the cycle the count reaches
  // MAX_LOCK, and that cycle still serves the owner.
  always_comb begin
    lock_cnt_inc = (lock_cnt_q == CNT_MAX) ? lock_cnt_q : lock_cnt_q + CNT_W'(1);
    lock_timeout = (lock_cnt_inc == CNT_MAX);
    owner_lock   = (state_q == ST_LOCK1) ? i_Lock_1 : i_Lock_0;
  end

  // Lock FSM, timeout counter and round-robin history.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= ST_IDLE;
      lock_cnt_q <= '0;
      last_q     <= 1'b1;  // M0 wins the first tie
    end else begin
      // In LOCKm only m can be granted, so last_q already equals the owner
      // when a timeout drops back to IDLE; the other master wins next tie.
      if (gnt[M0]) begin
        last_q <= 1'b0;
      end else if (gnt[M1]) begin
        last_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (gnt[M0] && i_Lock_0) begin
            state_q    <= ST_LOCK0;
            lock_cnt_q <= CNT_W'(1);
          end else if (gnt[M1] && i_Lock_1) begin
            state_q    <= ST_LOCK1;
            lock_cnt_q <= CNT_W'(1);
          end
        end
        ST_LOCK0, ST_LOCK1: begin
          // Dropping the lock ends the sequence whether or not the owner
          // is issuing an operation this cycle.
          if (!owner_lock || lock_timeout) begin
            state_q    <= ST_IDLE;
            lock_cnt_q <= '0;
          end else begin
            lock_cnt_q <= lock_cnt_inc;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          lock_cnt_q <= '0;
        end
      endcase
    end
  end

  // Read-return tracking: one pending bit per master, valid the next cycle.
  assign rd_pend_d = gnt & ~wr;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rd_pend_q <= 2'b00;
    end else begin
      rd_pend_q <= rd_pend_d;
    end
  end

  assign o_RValid_0 = rd_pend_q[M0];
  assign o_RValid_1 = rd_pend_q[M1];
  assign o_RData_0  = rd_pend_q[M0] ? i_RData : '0;
  assign o_RData_1  = rd_pend_q[M1] ? i_RData : '0;

  // Downstream forwarding; everything idles at 0 when nothing is granted.
  always_comb begin
    o_WEnable = 1'b0;
    o_WAddr   = '0;
    o_WData   = '0;
    o_REnable = 1'b0;
    o_RAddr   = '0;
    if (gnt[M0]) begin
      if (i_Wr_0) begin
        o_WEnable = 1'b1;
        o_WAddr   = i_Addr_0;
        o_WData   = i_WData_0;
      end else begin
        o_REnable = 1'b1;
        o_RAddr   = i_Addr_0;
      end
    end else if (gnt[M1]) begin
      if (i_Wr_1) begin
        o_WEnable = 1'b1;
        o_WAddr   = i_Addr_1;
        o_WData   = i_WData_1;
      end else begin
        o_REnable = 1'b1;
        o_RAddr   = i_Addr_1;
      end
    end
  end

endmodule : bus_master_arbiter

// File: tb/tb_bus_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_master_arbiter
// Directed bench: reset, round-robin tie, single write, lock hand-over,
// lock timeout with an active owner, idle-owner timeout, reset mid-read.
// Inputs change 1 ns after the rising edge; outputs are sampled 1-2 ns later.
// ---------------------------------------------------------------------------
module tb_bus_master_arbiter;

  localparam int BW = 32;

  logic          clk;
  logic          rst_n;
  logic          req0, wr0, lock0, req1, wr1, lock1;
  logic [BW-1:0] addr0, wdata0, addr1, wdata1, rdata;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [BW-1:0] rdata0, rdata1;
  logic          wen, ren;
  logic [BW-1:0] waddr, wdata, raddr;

  int vectors;
  int miscompares;

  bus_master_arbiter #(.BUS_WIDTH(BW), .MAX_LOCK(16)) dut (
    .i_Clk      (clk),
    .i_Rst_n    (rst_n),
    .i_Req_0    (req0),
    .i_Wr_0     (wr0),
    .i_Addr_0   (addr0),
    .i_WData_0  (wdata0),
    .i_Lock_0   (lock0),
    .o_Gnt_0    (gnt0),
    .o_RValid_0 (rvalid0),
    .o_RData_0  (rdata0),
    .i_Req_1    (req1),
    .i_Wr_1     (wr1),
    .i_Addr_1   (addr1),
    .i_WData_1  (wdata1),
    .i_Lock_1   (lock1),
    .o_Gnt_1    (gnt1),
    .o_RValid_1 (rvalid1),
    .o_RData_1  (rdata1),
    .o_WEnable  (wen),
    .o_WAddr    (waddr),
    .o_WData    (wdata),
    .o_REnable  (ren),
    .o_RAddr    (raddr),
    .i_RData    (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    req0 = 0; wr0 = 0; lock0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; wr1 = 0; lock1 = 0; addr1 = '0; wdata1 = '0;
    rdata = 32'hFFFF_FFFF;

    // ---- Reset state ----
    repeat (2) @(posedge clk);
    #2;
    check("rst_gnt0",    gnt0,    1'b0);
    check("rst_gnt1",    gnt1,    1'b0);
    check("rst_rvalid0", rvalid0, 1'b0);
    check("rst_rvalid1", rvalid1, 1'b0);
    check("rst_rdata0",  rdata0,  32'h0);
    check("rst_wen",     wen,     1'b0);
    check("rst_ren",     ren,     1'b0);
    check("rst_waddr",   waddr,   32'h0);
    rst_n = 1'b1;
    tick();

    // ---- Tie: both read, grants alternate starting with M0 ----
    req0 = 1; wr0 = 0; addr0 = 32'h010;
    req1 = 1; wr1 = 0; addr1 = 32'h404;
    #1;
    check("tie1_gnt0",  gnt0,  1'b1);
    check("tie1_gnt1",  gnt1,  1'b0);
    check("tie1_ren",   ren,   1'b1);
    check("tie1_raddr", raddr, 32'h010);
    check("tie1_wen",   wen,   1'b0);
    tick();
    rdata = 32'hA0A0_0010;
    #1;
    check("tie2_gnt0",    gnt0,    1'b0);
    check("tie2_gnt1",    gnt1,    1'b1);
    check("tie2_raddr",   raddr,   32'h404);
    check("tie2_rvalid0", rvalid0, 1'b1);
    check("tie2_rdata0",  rdata0,  32'hA0A0_0010);
    check("tie2_rvalid1", rvalid1, 1'b0);
    tick();
    rdata = 32'hB1B1_0404;
    #1;
    check("tie3_gnt0",    gnt0,    1'b1);
    check("tie3_raddr",   raddr,   32'h010);
    check("tie3_rvalid1", rvalid1, 1'b1);
    check("tie3_rdata1",  rdata1,  32'hB1B1_0404);
    check("tie3_rvalid0", rvalid0, 1'b0);
    check("tie3_rdata0",  rdata0,  32'h0);
    tick();
    rdata = 32'hA0A0_0011;
    #1;
    check("tie4_gnt1",    gnt1,    1'b1);
    check("tie4_rvalid0", rvalid0, 1'b1);
    check("tie4_rdata0",  rdata0,  32'hA0A0_0011);
    tick();
    req0 = 0; req1 = 0;
    rdata = 32'hB1B1_0405;
    #1;
    check("tie5_gnt0",    gnt0,    1'b0);
    check("tie5_gnt1",    gnt1,    1'b0);
    check("tie5_ren",     ren,     1'b0);
    check("tie5_raddr",   raddr,   32'h0);
    check("tie5_rvalid1", rvalid1, 1'b1);
    check("tie5_rdata1",  rdata1,  32'hB1B1_0405);
    tick();

    // ---- Single write from M1 ----
    req1 = 1; wr1 = 1; addr1 = 32'h408; wdata1 = 32'hDEAD_BEEF;
    rdata = 32'h5555_5555;
    #1;
    check("wr_gnt1",    gnt1,    1'b1);
    check("wr_gnt0",    gnt0,    1'b0);
    check("wr_wen",     wen,     1'b1);
    check("wr_waddr",   waddr,   32'h408);
    check("wr_wdata",   wdata,   32'hDEAD_BEEF);
    check("wr_ren",     ren,     1'b0);
    check("wr_rvalid1", rvalid1, 1'b0);
    tick();
    req1 = 0; wr1 = 0;
    #1;
    check("wr2_rvalid1", rvalid1, 1'b0);
    check("wr2_rdata1",  rdata1,  32'h0);
    check("wr2_wen",     wen,     1'b0);
    tick();

    // ---- Lock: M0 read+write atomic, M1 waits ----
    req0 = 1; wr0 = 0; addr0 = 32'h020; lock0 = 1;
    req1 = 1; wr1 = 0; addr1 = 32'h400;
    #1;
    check("lk1_gnt0",  gnt0,  1'b1);
    check("lk1_gnt1",  gnt1,  1'b0);
    check("lk1_raddr", raddr, 32'h020);
    tick();
    wr0 = 1; wdata0 = 32'h1234_5678; lock0 = 0;
    rdata = 32'hC0C0_0020;
    #1;
    check("lk2_gnt0",    gnt0,    1'b1);
    check("lk2_gnt1",    gnt1,    1'b0);
    check("lk2_wen",     wen,     1'b1);
    check("lk2_waddr",   waddr,   32'h020);
    check("lk2_wdata",   wdata,   32'h1234_5678);
    check("lk2_rvalid0", rvalid0, 1'b1);
    check("lk2_rdata0",  rdata0,  32'hC0C0_0020);
    tick();
    req0 = 0; wr0 = 0;
    #1;
    check("lk3_gnt1",  gnt1,  1'b1);
    check("lk3_gnt0",  gnt0,  1'b0);
    check("lk3_raddr", raddr, 32'h400);
    tick();
    req1 = 0;
    rdata = 32'hD0D0_0400;
    #1;
    check("lk4_rvalid1", rvalid1, 1'b1);
    check("lk4_rdata1",  rdata1,  32'hD0D0_0400);
    tick();

    // ---- Timeout with owner active: 16 owner grants, then M1 ----
    req0 = 1; wr0 = 0; addr0 = 32'h030; lock0 = 1;
    req1 = 1; wr1 = 0; addr1 = 32'h430;
    for (int i = 1; i <= 16; i++) begin
      #1;
      check($sformatf("to_gnt0_c%0d", i), gnt0, 1'b1);
      check($sformatf("to_gnt1_c%0d", i), gnt1, 1'b0);
      tick();
    end
    #1;
    check("to_gnt1_c17",  gnt1,  1'b1);
    check("to_gnt0_c17",  gnt0,  1'b0);
    check("to_raddr_c17", raddr, 32'h430);
    tick();
    req0 = 0; lock0 = 0; req1 = 0;
    #1;
    check("to_idle_gnt0", gnt0, 1'b0);
    check("to_idle_gnt1", gnt1, 1'b0);
    tick();

    // ---- Idle owner holding lock: nobody granted until timeout ----
    req0 = 1; wr0 = 0; addr0 = 32'h040; lock0 = 1;
    #1;
    check("il1_gnt0", gnt0, 1'b1);
    tick();
    req0 = 0;
    req1 = 1; wr1 = 0; addr1 = 32'h440;
    for (int i = 2; i <= 16; i++) begin
      #1;
      check($sformatf("il_gnt1_c%0d", i), gnt1, 1'b0);
      check($sformatf("il_gnt0_c%0d", i), gnt0, 1'b0);
      tick();
    end
    #1;
    check("il_gnt1_c17",  gnt1,  1'b1);
    check("il_raddr_c17", raddr, 32'h440);
    tick();
    req1 = 0; lock0 = 0;
    tick();

    // ---- Reset asserted mid-read: pending read is discarded ----
    req0 = 1; wr0 = 0; addr0 = 32'h050;
    #1;
    check("rr1_gnt0", gnt0, 1'b1);
    tick();
    rdata = 32'hE0E0_0050;
    #1;
    check("rr2_rvalid0", rvalid0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rr_async_rvalid0", rvalid0, 1'b0);
    check("rr_async_rdata0",  rdata0,  32'h0);
    check("rr_async_gnt0",    gnt0,    1'b0);
    check("rr_async_ren",     ren,     1'b0);
    check("rr_async_raddr",   raddr,   32'h0);
    tick();
    req0 = 0;
    rst_n = 1'b1;
    #1;
    check("rr_rel_rvalid0", rvalid0, 1'b0);
    tick();
    #1;
    check("rr_post_rvalid0", rvalid0, 1'b0);
    check("rr_post_rdata0",  rdata0,  32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_bus_master_arbiter
